// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing stage: default 640x480@60 timing,
// counter widths and the RGB565 colours used by the colour-bar generator.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Colour of bar idx, left (0) to right (7).
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_cnt.sv
// Horizontal/vertical scan counters; v_cnt advances on each h_cnt wrap.
module vga_scan_cnt
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [HCNT_W-1:0] h_cnt,
  output logic [VCNT_W-1:0] v_cnt,
  output logic              line_wrap
);

  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;

  assign line_wrap = (h_cnt_q == HCNT_W'(H_TOTAL - 1));
  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;

  always_comb begin
    h_cnt_d = h_cnt_q + HCNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (line_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VCNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + VCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing and pixel-output stage: scan decode, line-FIFO pop, 2-stage output
// pipeline and underflow counter. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIX_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [PIX_W-1:0]  fifo_rd_data,
  input  logic              fifo_empty,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [PIX_W-1:0]  vga_rgb,
  output logic [HCNT_W-1:0] pix_x,
  output logic [VCNT_W-1:0] pix_y,
  output logic              frame_start,
  output logic [15:0]       underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [HCNT_W-1:0] h_cnt;
  logic [VCNT_W-1:0] v_cnt;
  logic              line_wrap;

  vga_scan_cnt #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .line_wrap(line_wrap)
  );

  logic active0, hs0, vs0, pat0, uf0;
  // sof_q is high exactly while the counters sit at (0,0); reset lands there too.
  logic sof_q, sof_d;

`ifdef VGA_TEST_PATTERN_EN
  assign pat0 = pattern_sel;
`else
  assign pat0 = 1'b0;
`endif

  always_comb begin
    active0    = (h_cnt < HCNT_W'(H_ACTIVE)) && (v_cnt < VCNT_W'(V_ACTIVE));
    hs0        = ((h_cnt >= HCNT_W'(HS_BEG)) && (h_cnt < HCNT_W'(HS_END))) ? SYNC_POL : ~SYNC_POL;
    vs0        = ((v_cnt >= VCNT_W'(VS_BEG)) && (v_cnt < VCNT_W'(VS_END))) ? SYNC_POL : ~SYNC_POL;
    fifo_rd_en = active0 && !fifo_empty && !pat0 && !rst;
    uf0        = active0 && fifo_empty && !pat0;
    sof_d      = line_wrap && (v_cnt == VCNT_W'(V_TOTAL - 1));
  end

  // Stage 1
  logic              de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic              rd_ok1_q, rd_ok1_d, uf1_q, uf1_d, fs1_q, fs1_d, pat1_q, pat1_d;
  logic [HCNT_W-1:0] x1_q, x1_d;
  logic [VCNT_W-1:0] y1_q, y1_d;

  always_comb begin
    de1_d    = active0;
    hs1_d    = hs0;
    vs1_d    = vs0;
    x1_d     = h_cnt;
    y1_d     = v_cnt;
    rd_ok1_d = fifo_rd_en;
    uf1_d    = uf0;
    fs1_d    = sof_q;
    pat1_d   = pat0;
  end

  // Stage 2 (pins); FIFO data arrives during stage 1, one cycle after the pop.
  logic              de_q, hs_q, vs_q, fs_q;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic [HCNT_W-1:0] x_q;
  logic [VCNT_W-1:0] y_q;
  logic [15:0]       ucnt_q, ucnt_d;
  logic [HCNT_W-1:0] bar_div;
  logic [2:0]        bar_idx;

  always_comb begin
    bar_div = x1_q / HCNT_W'(BAR_W);
    bar_idx = (bar_div > HCNT_W'(7)) ? 3'd7 : bar_div[2:0];
    rgb_d   = '0;
    if (de1_q && pat1_q)
      rgb_d = PIX_W'(bar_colour(bar_idx));
    else if (rd_ok1_q)
      rgb_d = fifo_rd_data;
    ucnt_d = ucnt_q;
    if (uf1_q && (ucnt_q != 16'hFFFF))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_q    <= 1'b1;
      de1_q    <= 1'b0;
      hs1_q    <= ~SYNC_POL;
      vs1_q    <= ~SYNC_POL;
      x1_q     <= '0;
      y1_q     <= '0;
      rd_ok1_q <= 1'b0;
      uf1_q    <= 1'b0;
      fs1_q    <= 1'b0;
      pat1_q   <= 1'b0;
      de_q     <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      fs_q     <= 1'b0;
      rgb_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ucnt_q   <= '0;
    end else begin
      sof_q    <= sof_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      rd_ok1_q <= rd_ok1_d;
      uf1_q    <= uf1_d;
      fs1_q    <= fs1_d;
      pat1_q   <= pat1_d;
      de_q     <= de1_q;
      hs_q     <= hs1_q;
      vs_q     <= vs1_q;
      fs_q     <= fs1_q;
      rgb_q    <= rgb_d;
      x_q      <= x1_q;
      y_q      <= y1_q;
      ucnt_q   <= ucnt_d;
    end
  end

  assign vga_de        = de_q;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_rgb       = rgb_q;
  assign pix_x         = x_q;
  assign pix_y         = y_q;
  assign frame_start   = fs_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 64x16 raster (80x23 totals)
// so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 16, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;   // 80
  localparam int VT = VA + VFP + VSW + VBP;   // 23
  localparam int FRAME = HT * VT;             // 1840
  localparam int UF_LINE = 5, UF_X = 20, UF_LEN = 10;
  localparam int RST_LINE = 10, RST_X = 30;
  localparam int UF_SPAN = 7 * HT;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_sel;
`endif
  logic        vga_hs, vga_vs, vga_de, frame_start;
  logic [15:0] vga_rgb, underflow_cnt;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [15:0] word_q;

  int checks = 0;
  int errors = 0;
  int cur_t  = 0;

  always #5 clk = ~clk;

  // Line FIFO model: incrementing words, 1-cycle read latency, restarts on rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q       <= 16'd0;
      fifo_rd_data <= 16'd0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= word_q;
      word_q       <= word_q + 16'd1;
    end
  end

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIX_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel  (pattern_sel),
`endif
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_de       (vga_de),
    .vga_rgb      (vga_rgb),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_start  (frame_start),
    .underflow_cnt(underflow_cnt)
  );

  task automatic test_reset();
    rst = 1'b1;
    fifo_empty = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b want 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b want 1", vga_vs); end
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", vga_de); end
    checks++; if (vga_rgb !== 16'h0) begin errors++; $display("FAIL reset_rgb: got %h want 0", vga_rgb); end
    checks++; if (pix_x !== 11'd0 || pix_y !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", pix_x, pix_y); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    checks++; if (underflow_cnt !== 16'h0) begin errors++; $display("FAIL reset_ucnt: got %0d want 0", underflow_cnt); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
  endtask

  task automatic test_stream();
    int bad_rd = 0, bad_de = 0, bad_sync = 0, bad_rgb = 0, bad_xy = 0, bad_fs = 0, bad_gap = 0;
    int pops, hs_low = 0, vs_low = 0, fs_cnt = 0, last_fs = -1, first_de = -1;
    int p, h, v, f;
    logic act, ehs, evs;
    logic [15:0] ergb;
    @(negedge clk);
    rst = 1'b0;
    fifo_empty = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL first_pop: rd_en got %b want 1", fifo_rd_en); end
    pops = (fifo_rd_en === 1'b1) ? 1 : 0;
    for (int t = 1; t <= 2 * FRAME + 4; t++) begin
      @(negedge clk);
      h = t % HT; v = (t / HT) % VT;
      act = (h < HA) && (v < VA);
      if (fifo_rd_en !== act) bad_rd++;
      if (fifo_rd_en === 1'b1 && t < FRAME) pops++;
      if (t >= 2) begin
        p = t - 2; h = p % HT; v = (p / HT) % VT; f = p / FRAME;
        act  = (h < HA) && (v < VA);
        ehs  = !(h >= HA + HFP && h < HA + HFP + HSW);
        evs  = !(v >= VA + VFP && v < VA + VFP + VSW);
        ergb = act ? 16'(f * HA * VA + v * HA + h) : 16'd0;
        if (vga_de !== act) bad_de++;
        if (vga_hs !== ehs || vga_vs !== evs) bad_sync++;
        if (vga_rgb !== ergb) bad_rgb++;
        if (act && (pix_x !== 11'(h) || pix_y !== 10'(v))) bad_xy++;
        if (frame_start !== (h == 0 && v == 0)) bad_fs++;
        if (vga_hs === 1'b0 && v == 3 && f == 0) hs_low++;
        if (vga_vs === 1'b0 && f == 0) vs_low++;
      end else begin
        if (vga_de !== 1'b0) bad_de++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1) bad_sync++;
        if (vga_rgb !== 16'd0) bad_rgb++;
        if (frame_start !== 1'b0) bad_fs++;
      end
      if (vga_de === 1'b1 && first_de < 0) first_de = t;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0 && (t - last_fs) != FRAME) bad_gap++;
        last_fs = t;
        fs_cnt++;
      end
    end
    cur_t = 2 * FRAME + 4;
    checks++; if (first_de !== 2) begin errors++; $display("FAIL first_de: got cycle %0d want 2", first_de); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL stream_rd_en: %0d bad cycles, want 0", bad_rd); end
    checks++; if (bad_de !== 0) begin errors++; $display("FAIL stream_de: %0d bad cycles, want 0", bad_de); end
    checks++; if (bad_sync !== 0) begin errors++; $display("FAIL stream_sync: %0d bad cycles, want 0", bad_sync); end
    checks++; if (bad_rgb !== 0) begin errors++; $display("FAIL stream_rgb: %0d bad cycles, want 0", bad_rgb); end
    checks++; if (bad_xy !== 0) begin errors++; $display("FAIL stream_xy: %0d bad cycles, want 0", bad_xy); end
    checks++; if (bad_fs !== 0) begin errors++; $display("FAIL stream_fs: %0d bad cycles, want 0", bad_fs); end
    checks++; if (hs_low !== HSW) begin errors++; $display("FAIL hs_width: got %0d want %0d", hs_low, HSW); end
    checks++; if (vs_low !== VSW * HT) begin errors++; $display("FAIL vs_width: got %0d want %0d", vs_low, VSW * HT); end
    checks++; if (pops !== HA * VA) begin errors++; $display("FAIL pops_per_frame: got %0d want %0d", pops, HA * VA); end
    checks++; if (fs_cnt !== 3 || bad_gap !== 0) begin errors++; $display("FAIL fs_period: got %0d pulses, %0d bad gaps, want 3 and 0", fs_cnt, bad_gap); end
  endtask

  task automatic test_underflow();
    int exp_rgb [UF_SPAN];
    int exp_uc  [UF_SPAN];
    int words = 0, starved = 0, bad_rd = 0, bad_rgb = 0, bad_uc = 0, zeros = 0;
    int h, v, p;
    logic act, emp;
    logic [15:0] pix_after = 16'hDEAD;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < UF_SPAN; t++) begin
      h = t % HT; v = t / HT;
      act = (h < HA) && (v < VA);
      emp = (v == UF_LINE) && (h >= UF_X) && (h < UF_X + UF_LEN);
      fifo_empty = emp;
      #1;
      if (fifo_rd_en !== (act && !emp)) bad_rd++;
      if (act && !emp) begin
        exp_rgb[t] = words;
        words++;
      end else begin
        exp_rgb[t] = 0;
        if (act) starved++;
      end
      exp_uc[t] = starved;
      if (t >= 2) begin
        p = t - 2;
        if (vga_rgb !== 16'(exp_rgb[p])) bad_rgb++;
        if (underflow_cnt !== 16'(exp_uc[p])) bad_uc++;
        if (p / HT == UF_LINE && p % HT >= UF_X && p % HT < UF_X + UF_LEN &&
            vga_de === 1'b1 && vga_rgb === 16'd0) zeros++;
        if (p == UF_LINE * HT + UF_X + UF_LEN) pix_after = vga_rgb;
      end
      @(negedge clk);
    end
    fifo_empty = 1'b0;
    cur_t = UF_SPAN;
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL uf_rd_en: %0d bad cycles, want 0", bad_rd); end
    checks++; if (bad_rgb !== 0) begin errors++; $display("FAIL uf_rgb: %0d bad cycles, want 0", bad_rgb); end
    checks++; if (bad_uc !== 0) begin errors++; $display("FAIL uf_cnt_track: %0d bad cycles, want 0", bad_uc); end
    checks++; if (zeros !== UF_LEN) begin errors++; $display("FAIL uf_zero_pixels: got %0d want %0d", zeros, UF_LEN); end
    checks++; if (pix_after !== 16'd340) begin errors++; $display("FAIL uf_resume_pixel: got %0d want 340", pix_after); end
    checks++; if (underflow_cnt !== 16'd10) begin errors++; $display("FAIL uf_count: got %0d want 10", underflow_cnt); end
  endtask

  task automatic test_reset_mid();
    while (cur_t < RST_LINE * HT + RST_X) begin
      @(negedge clk);
      cur_t++;
    end
    checks++; if (underflow_cnt !== 16'd10 || fifo_rd_en !== 1'b1) begin errors++; $display("FAIL pre_reset: ucnt %0d rd_en %b want 10 1", underflow_cnt, fifo_rd_en); end
    rst = 1'b1;
    #1;
    checks++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin errors++; $display("FAIL mid_reset_sync: hs %b vs %b want 1 1", vga_hs, vga_vs); end
    checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL mid_reset_de: got %b want 0", vga_de); end
    checks++; if (vga_rgb !== 16'd0) begin errors++; $display("FAIL mid_reset_rgb: got %h want 0", vga_rgb); end
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_ucnt: got %0d want 0", underflow_cnt); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_reset_rd_en: got %b want 0", fifo_rd_en); end
    repeat (3) @(negedge clk);
    checks++; if (vga_de !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL reset_hold: de %b fs %b want 0 0", vga_de, frame_start); end
    rst = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL release_pop: got %b want 1", fifo_rd_en); end
    @(negedge clk);
    checks++; if (frame_start !== 1'b0 || vga_de !== 1'b0) begin errors++; $display("FAIL release_c1: fs %b de %b want 0 0", frame_start, vga_de); end
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL release_fs: got %b want 1", frame_start); end
    checks++; if (vga_de !== 1'b1 || vga_rgb !== 16'd0 || pix_x !== 11'd0 || pix_y !== 10'd0) begin
      errors++; $display("FAIL release_pixel0: de %b rgb %0d x %0d y %0d want 1 0 0 0", vga_de, vga_rgb, pix_x, pix_y); end
    @(negedge clk);
    checks++; if (frame_start !== 1'b0 || vga_rgb !== 16'd1) begin errors++; $display("FAIL release_pixel1: fs %b rgb %0d want 0 1", frame_start, vga_rgb); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [15:0] bars [8];
    int bad_rd = 0, bad_rgb = 0, h, v, p;
    logic [15:0] ergb, c0 = 16'hDEAD, c8 = 16'hDEAD, c63 = 16'hDEAD;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    rst = 1'b1;
    pattern_sel = 1'b1;
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < HT + 3; t++) begin
      #1;
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (t >= 2) begin
        p = t - 2; h = p % HT; v = p / HT;
        ergb = (h < HA && v < VA) ? bars[h / (HA / 8)] : 16'd0;
        if (vga_rgb !== ergb) bad_rgb++;
        if (p == 0) c0 = vga_rgb;
        if (p == 8) c8 = vga_rgb;
        if (p == 63) c63 = vga_rgb;
      end
      @(negedge clk);
    end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL pat_rd_en: %0d pops, want 0", bad_rd); end
    checks++; if (bad_rgb !== 0) begin errors++; $display("FAIL pat_rgb: %0d bad cycles, want 0", bad_rgb); end
    checks++; if (c0 !== 16'hFFFF || c8 !== 16'hFFE0 || c63 !== 16'h0000) begin
      errors++; $display("FAIL pat_bars: got %h %h %h want FFFF FFE0 0000", c0, c8, c63); end
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL pat_ucnt: got %0d want 0", underflow_cnt); end
    pattern_sel = 1'b0;
    fifo_empty = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    fifo_empty = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    test_reset();
    test_stream();
    test_underflow();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
